brq_lsu: RTL and testbench

Load/store unit sitting between the execute stage and the data closely-coupled memory (DCCM). It accepts one byte-addressed load or store request at a time and checks it for alignment and range. It converts the request into the DCCM word address, lane-select code and enables, then returns sign- or zero-extended load data, or store completion, over a valid/ready response channel. It is non-pipelined: one outstanding request.

---
 rtl/brq_lsu.sv | 168 ++++++++++++++++
 tb/tb_brq_lsu.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/brq_lsu.sv
// brq_lsu: non-pipelined load/store unit between execute and the DCCM.
// Accepts one byte-addressed load or store, checks size, alignment and
// range, performs a single DCCM access and returns extended load data or
// store completion over a valid/ready response channel.
//
// Ports:
//   brq_clk, brq_rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_we, req_size,
//   req_unsigned, req_addr,
//   req_wdata                   request fields (store data right-justified)
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_err          extended load data / error flag
//   dccm_address                word address (byte address bits [AddrWidth+1:2])
//   dccm_byte_enable            lane code, 111 = no-op
//   dccm_data_in                store data, unshifted
//   dccm_write_enable,
//   dccm_read_enable            one-cycle access strobes
//   dccm_data_out               combinational DCCM read data
module brq_lsu #(
  parameter int AddrWidth = 15,
  parameter int DataWidth = 32
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [31:0]          req_addr,
  input  logic [DataWidth-1:0] req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DataWidth-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic [AddrWidth-1:0] dccm_address,
  output logic [2:0]           dccm_byte_enable,
  output logic [DataWidth-1:0] dccm_data_in,
  output logic                 dccm_write_enable,
  output logic                 dccm_read_enable,
  input  logic [DataWidth-1:0] dccm_data_out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_e;

  localparam logic [2:0] LaneNop = 3'b111;

  state_e               state;
  logic                 we_q;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic [AddrWidth+1:0] addr_q;
  logic                 req_bad;

  // Lane code for the DCCM: byte lanes 000..011, half lower 101 / upper 100,
  // word 110.
  function automatic logic [2:0] lane_code(input logic [1:0] size,
                                           input logic [1:0] lo);
    logic [2:0] code;
    case (size)
      2'b00:   code = {1'b0, lo};
      2'b01:   code = lo[1] ? 3'b100 : 3'b101;
      2'b10:   code = 3'b110;
      default: code = LaneNop;
    endcase
    return code;
  endfunction

  // Pick the addressed byte/half out of the read word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] d,
                                               input logic [1:0]  size,
                                               input logic        uns,
                                               input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (size)
      2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Illegal size, misalignment, or any address bit above the DCCM range.
  assign req_bad = (req_size == 2'b11) ||
                   (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                   (|req_addr[31:AddrWidth+2]);

  assign req_ready    = (state == IDLE);
  assign rsp_valid    = (state == RESP);
  assign dccm_address = addr_q[AddrWidth+1:2];

  // Single FSM; the DCCM strobes and lane code are registered on acceptance
  // so they are high exactly during ACCESS and drop at once on reset.
  always_ff @(posedge brq_clk or negedge brq_rst_n) begin
    if (!brq_rst_n) begin
      state             <= IDLE;
      we_q              <= 1'b0;
      size_q            <= 2'b00;
      uns_q             <= 1'b0;
      addr_q            <= '0;
      dccm_data_in      <= '0;
      dccm_write_enable <= 1'b0;
      dccm_read_enable  <= 1'b0;
      dccm_byte_enable  <= LaneNop;
      rsp_rdata         <= '0;
      rsp_err           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q         <= req_we;
            size_q       <= req_size;
            uns_q        <= req_unsigned;
            addr_q       <= req_addr[AddrWidth+1:0];
            dccm_data_in <= req_wdata;
            if (req_bad) begin
              state <= ERR;
            end else begin
              state             <= ACCESS;
              dccm_write_enable <= req_we;
              dccm_read_enable  <= ~req_we;
              dccm_byte_enable  <= lane_code(req_size, req_addr[1:0]);
            end
          end
        end
        ACCESS: begin
          dccm_write_enable <= 1'b0;
          dccm_read_enable  <= 1'b0;
          dccm_byte_enable  <= LaneNop;
          rsp_err           <= 1'b0;
          rsp_rdata         <= we_q ? '0
                               : load_extract(dccm_data_out, size_q, uns_q, addr_q[1:0]);
          state             <= RESP;
        end
        ERR: begin
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brq_lsu.sv
// tb_brq_lsu: directed self-checking bench for brq_lsu with a small
// byte-lane-aware DCCM model and strobe/acceptance counters.
module tb_brq_lsu;

  localparam int AddrWidth = 15;

  logic                 brq_clk;
  logic                 brq_rst_n;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [1:0]           req_size;
  logic                 req_unsigned;
  logic [31:0]          req_addr;
  logic [31:0]          req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_rdata;
  logic                 rsp_err;
  logic [AddrWidth-1:0] dccm_address;
  logic [2:0]           dccm_byte_enable;
  logic [31:0]          dccm_data_in;
  logic                 dccm_write_enable;
  logic                 dccm_read_enable;
  logic [31:0]          dccm_data_out;

  logic [31:0] mem [0:(1<<AddrWidth)-1];

  int          wr_count;
  int          rd_count;
  int          acc_count;
  logic [31:0] last_wr_addr;
  logic [31:0] last_wr_be;
  logic [31:0] last_rd_be;

  int          n_checks;
  int          n_errors;

  brq_lsu #(.AddrWidth(AddrWidth), .DataWidth(32)) dut (
    .brq_clk           (brq_clk),
    .brq_rst_n         (brq_rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_we            (req_we),
    .req_size          (req_size),
    .req_unsigned      (req_unsigned),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_rdata         (rsp_rdata),
    .rsp_err           (rsp_err),
    .dccm_address      (dccm_address),
    .dccm_byte_enable  (dccm_byte_enable),
    .dccm_data_in      (dccm_data_in),
    .dccm_write_enable (dccm_write_enable),
    .dccm_read_enable  (dccm_read_enable),
    .dccm_data_out     (dccm_data_out)
  );

  initial brq_clk = 1'b0;
  always #5 brq_clk = ~brq_clk;

  assign dccm_data_out = mem[dccm_address];

  // DCCM model: merge store data into the selected lane(s).
  always @(posedge brq_clk) begin
    if (dccm_write_enable) begin
      case (dccm_byte_enable)
        3'b000: mem[dccm_address][7:0]   <= dccm_data_in[7:0];
        3'b001: mem[dccm_address][15:8]  <= dccm_data_in[7:0];
        3'b010: mem[dccm_address][23:16] <= dccm_data_in[7:0];
        3'b011: mem[dccm_address][31:24] <= dccm_data_in[7:0];
        3'b101: mem[dccm_address][15:0]  <= dccm_data_in[15:0];
        3'b100: mem[dccm_address][31:16] <= dccm_data_in[15:0];
        3'b110: mem[dccm_address]        <= dccm_data_in;
        default: ;
      endcase
    end
  end

  // Strobe and acceptance bookkeeping.
  initial begin
    wr_count  = 0;
    rd_count  = 0;
    acc_count = 0;
  end

  always @(posedge brq_clk) begin
    if (dccm_write_enable) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= 32'(dccm_address);
      last_wr_be   <= 32'(dccm_byte_enable);
    end
    if (dccm_read_enable) begin
      rd_count   <= rd_count + 1;
      last_rd_be <= 32'(dccm_byte_enable);
    end
    if (req_valid && req_ready) acc_count <= acc_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Issue one request, wait (bounded) for the response, then complete the
  // handshake with rsp_ready held high. lat counts edges after acceptance.
  task automatic applyStimulus(input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err,
                               output int lat);
    int waited;
    lat   = 0;
    rdata = '0;
    err   = 1'b0;
    @(negedge brq_clk);
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge brq_clk);
      waited++;
    end
    if (!req_ready) checkOutput("ready_timeout", 32'(req_ready), 32'd1);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
    @(posedge brq_clk);
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge brq_clk);
      #1;
      if (rsp_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) checkOutput("rsp_timeout", 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge brq_clk);
    #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          wr0;
  int          rd0;
  int          acc0;

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    brq_rst_n    = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    rsp_ready    = 1'b1;

    // Reset state
    repeat (3) @(posedge brq_clk);
    @(negedge brq_clk);
    brq_rst_n = 1'b1;
    #1;
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("rst_be", 32'(dccm_byte_enable), 32'h7);
    checkOutput("rst_we", 32'(dccm_write_enable), 32'd0);
    checkOutput("rst_re", 32'(dccm_read_enable), 32'd0);
    checkOutput("rst_addr", 32'(dccm_address), 32'd0);

    // Word store then load
    wr0 = wr_count;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checkOutput("sw_err", 32'(er), 32'd0);
    checkOutput("sw_rdata", rd, 32'd0);
    checkOutput("sw_writes", 32'(wr_count - wr0), 32'd1);
    checkOutput("sw_waddr", last_wr_addr, 32'd4);
    checkOutput("sw_code", last_wr_be, 32'h6);
    checkOutput("sw_lat", 32'(lat), 32'd1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, er, lat);
    checkOutput("lw_rdata", rd, 32'hDEADBEEF);
    checkOutput("lw_err", 32'(er), 32'd0);
    checkOutput("lw_lat", 32'(lat), 32'd1);

    // Byte lanes and extension
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01, rd, er, lat);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, rd, er, lat);
    checkOutput("lb_23", rd, 32'hFFFFFF80);
    checkOutput("lb_23_code", last_rd_be, 32'h3);
    applyStimulus(1'b0, 2'b00, 1'b1, 32'h23, 32'h0, rd, er, lat);
    checkOutput("lbu_23", rd, 32'h00000080);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, rd, er, lat);
    checkOutput("lb_21", rd, 32'h0000007F);

    // Half lanes
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, rd, er, lat);
    checkOutput("lh_22", rd, 32'hFFFF80FF);
    checkOutput("lh_22_code", last_rd_be, 32'h4);
    applyStimulus(1'b0, 2'b01, 1'b1, 32'h20, 32'h0, rd, er, lat);
    checkOutput("lhu_20", rd, 32'h00007F01);
    checkOutput("lhu_20_code", last_rd_be, 32'h5);

    // Byte store into lane 2
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h22, 32'h000000AA, rd, er, lat);
    checkOutput("sb_22_code", last_wr_be, 32'h2);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, er, lat);
    checkOutput("sb_22_merge", rd, 32'h80AA7F01);

    // Error requests: no strobes, err set, data zero
    wr0 = wr_count;
    rd0 = rd_count;
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, rd, er, lat);
    checkOutput("lw_12_err", 32'(er), 32'd1);
    checkOutput("lw_12_rdata", rd, 32'd0);
    applyStimulus(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, rd, er, lat);
    checkOutput("lh_11_err", 32'(er), 32'd1);
    checkOutput("lh_11_rdata", rd, 32'd0);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h10, 32'h12345678, rd, er, lat);
    checkOutput("size11_err", 32'(er), 32'd1);
    checkOutput("size11_rdata", rd, 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h20000, 32'h0, rd, er, lat);
    checkOutput("range_err", 32'(er), 32'd1);
    checkOutput("range_rdata", rd, 32'd0);
    checkOutput("err_no_writes", 32'(wr_count - wr0), 32'd0);
    checkOutput("err_no_reads", 32'(rd_count - rd0), 32'd0);

    // Highest legal word address
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h1FFFC, 32'h12345678, rd, er, lat);
    checkOutput("top_sw_err", 32'(er), 32'd0);
    checkOutput("top_sw_waddr", last_wr_addr, 32'h7FFF);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h1FFFC, 32'h0, rd, er, lat);
    checkOutput("top_lw_rdata", rd, 32'h12345678);
    checkOutput("lw_10_intact", mem[4], 32'hDEADBEEF);

    // Backpressure with req_valid held high
    @(negedge brq_clk);
    acc0         = acc_count;
    rsp_ready    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    req_addr     = 32'h10;
    req_valid    = 1'b1;
    @(posedge brq_clk);
    #1 req_addr = 32'h20;
    for (int i = 0; i < 5; i++) begin
      @(posedge brq_clk);
      #1;
      checkOutput("bp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      checkOutput("bp_ready_low", 32'(req_ready), 32'd0);
    end
    @(negedge brq_clk);
    rsp_ready = 1'b1;
    @(posedge brq_clk);
    #1;
    checkOutput("bp_idle_ready", 32'(req_ready), 32'd1);
    @(posedge brq_clk);
    #1 req_valid = 1'b0;
    @(posedge brq_clk);
    #1;
    checkOutput("bp_next_valid", 32'(rsp_valid), 32'd1);
    checkOutput("bp_next_rdata", rsp_rdata, 32'h80AA7F01);
    @(posedge brq_clk);
    #1;
    checkOutput("bp_accepts", 32'(acc_count - acc0), 32'd2);

    // Reset during ACCESS of a store
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, rd, er, lat);
    @(negedge brq_clk);
    wr0          = wr_count;
    req_we       = 1'b1;
    req_size     = 2'b10;
    req_addr     = 32'h40;
    req_wdata    = 32'h00000055;
    req_valid    = 1'b1;
    @(posedge brq_clk);
    #1 req_valid = 1'b0;
    checkOutput("rs_access_we", 32'(dccm_write_enable), 32'd1);
    #2 brq_rst_n = 1'b0;
    #1;
    checkOutput("rs_we_drop", 32'(dccm_write_enable), 32'd0);
    checkOutput("rs_be_nop", 32'(dccm_byte_enable), 32'h7);
    checkOutput("rs_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge brq_clk);
    @(negedge brq_clk);
    brq_rst_n = 1'b1;
    #1;
    checkOutput("rs_ready", 32'(req_ready), 32'd1);
    checkOutput("rs_no_write", 32'(wr_count - wr0), 32'd0);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lat);
    checkOutput("rs_old_value", rd, 32'h11223344);

    $display("[TB] Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global bound in case the design stalls somewhere unexpected.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
